// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer bank.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat of press strobes).
package debounce_pkg;

  // Per-channel qualification state.
  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

  // Default timings at the board clock.
  localparam int DEF_STABLE_CYCLES = 10000;
  localparam int DEF_REPEAT_DELAY  = 5000000;
  localparam int DEF_REPEAT_PERIOD = 1000000;

  // Bits needed to hold values 0..count.
  function automatic int cnt_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stable-time qualifier FSM and strobes.
// Optional feature macro: DEBOUNCE_REPEAT_EN adds auto-repeat press strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic button_push,
  output logic level,
  output logic press,
  output logic release_strobe
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   samp;
  deb_state_t             state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   press_reg, release_reg;
  logic                   accept_rise, accept_fall;
  logic                   rpt_fire;

  assign samp = sync_reg[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_push};
  end

  // Qualify a change only after it has persisted for STABLE_CYCLES.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    level_next  = level_reg;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    case (state_reg)
      STABLE: begin
        if (samp != level_reg) begin
          state_next = CHANGING;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      CHANGING: begin
        if (samp == level_reg) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          level_next  = ~level_reg;
          accept_rise = ~level_reg;
          accept_fall = level_reg;
          state_next  = STABLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter, level and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= STABLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= accept_rise | rpt_fire;
      release_reg <= accept_fall;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX_VAL = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_width(RPT_MAX_VAL);
  localparam logic [RW-1:0] RPT_SAT = RW'(RPT_MAX_VAL);

  logic [RW-1:0] rpt_reg;
  logic [RW-1:0] rpt_inc;
  logic [RW-1:0] rpt_target;
  logic          armed_reg;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; an accepted
  // release suppresses any repeat in its own cycle.
  always_comb begin
    rpt_inc    = rpt_reg + 1'b1;
    rpt_target = armed_reg ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    rpt_fire   = level_reg & ~accept_fall & (rpt_reg != RPT_SAT) & (rpt_inc == rpt_target);
  end

  // Hold-time counter: restarts on every accepted edge and after each repeat.
  always_ff @(posedge clk) begin
    if (reset || accept_rise || accept_fall) begin
      rpt_reg   <= '0;
      armed_reg <= 1'b0;
    end else if (level_reg) begin
      if (rpt_fire) begin
        rpt_reg   <= '0;
        armed_reg <= 1'b1;
      end else if (rpt_reg != RPT_SAT) begin
        rpt_reg <= rpt_inc;
      end
    end
  end
`else
  // Repeat timing has no effect in this build; the expression is constant 0.
  assign rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  assign level          = level_reg;
  assign press          = press_reg;
  assign release_strobe = release_reg;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounced button channels.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat of press strobes).
// The release strobe port is release_strobe because release is a reserved word.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_push,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_strobe
);

  // One identical conditioner per button.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .button_push   (button_push[gi]),
      .level         (level[gi]),
      .press         (press[gi]),
      .release_strobe(release_strobe[gi])
    );
  end

endmodule
